// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

  // Bit offset of channel idx inside a packed bus of w-bit channels.
  function automatic int chan_lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] pending,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       valid
);
  assign valid = |pending;
  assign gnt   = (&pending) ? ~last_gnt : pending[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory channel between two masters with round-robin grants,
// holding each grant until the memory answers or the watchdog aborts the access.
module mem_port_arbiter #(
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int DATA_W  = mem_arb_pkg::DATA_W,
  parameter int SIZE_W  = mem_arb_pkg::SIZE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_oe,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*SIZE_W-1:0] req_size,
  output logic [2*DATA_W-1:0] req_rdata,
  output logic [1:0]          req_rdy,
  output logic                mem_oe,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [SIZE_W-1:0]   mem_size,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdy,
  output logic                err
);
  import mem_arb_pkg::*;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e        state;
  logic              gnt;
  logic              last_gnt;
  logic [WD_W-1:0]   wd;
  logic [1:0]        legal;
  logic [1:0]        bad;
  logic              pick;
  logic              pick_vld;
  logic [ADDR_W-1:0] addr_ch  [2];
  logic [DATA_W-1:0] wdata_ch [2];
  logic [SIZE_W-1:0] size_ch  [2];

  for (genvar i = 0; i < 2; i++) begin : g_chan
    assign addr_ch[i]  = req_addr[chan_lsb(i, ADDR_W) +: ADDR_W];
    assign wdata_ch[i] = req_wdata[chan_lsb(i, DATA_W) +: DATA_W];
    assign size_ch[i]  = req_size[chan_lsb(i, SIZE_W) +: SIZE_W];
  end

  // A master raising both strobes at once is malformed and never eligible.
  assign bad   = req_oe & req_we;
  assign legal = req_oe ^ req_we;

  rr_pick2 u_pick (
    .pending  (legal),
    .last_gnt (last_gnt),
    .gnt      (pick),
    .valid    (pick_vld)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      wd        <= '0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      req_rdy   <= '0;
      req_rdata <= '0;
      err       <= 1'b0;
    end else begin
      req_rdy <= '0;
      case (state)
        IDLE: begin
          if (|bad) err <= 1'b1;
          if (pick_vld) begin
            gnt       <= pick;
            last_gnt  <= pick;
            mem_oe    <= req_oe[pick];
            mem_we    <= req_we[pick];
            mem_addr  <= addr_ch[pick];
            mem_wdata <= wdata_ch[pick];
            mem_size  <= size_ch[pick];
            wd        <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A real answer wins over an abort landing on the same cycle.
          if (mem_rdy || wd == WD_LAST) begin
            if (gnt) req_rdata[DATA_W +: DATA_W] <= mem_rdy ? mem_rdata : '0;
            else     req_rdata[0 +: DATA_W]      <= mem_rdy ? mem_rdata : '0;
            if (!mem_rdy) err <= 1'b1;
            req_rdy[gnt] <= 1'b1;
            mem_oe       <= 1'b0;
            mem_we       <= 1'b0;
            state        <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int SIZE_W  = 6;
  localparam int TIMEOUT = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          req_oe, req_we, req_rdy;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata, req_rdata;
  logic [2*SIZE_W-1:0] req_size;
  logic                mem_oe, mem_we, err;
  logic                mem_rdy = 1'b0;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata = '0;
  logic [SIZE_W-1:0]   mem_size;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_rdata(req_rdata), .req_rdy(req_rdy),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Requester agents
  logic              r_oe [2];
  logic              r_we [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [SIZE_W-1:0] r_size [2];
  int                bad_hold [2];
  bit                auto_rq [2];
  int                done_cnt [2];

  // Memory responder configuration
  bit                rand_mode = 0, rand_delay = 0, spurious = 0, mem_hang = 0, mem_fixed_en = 0;
  int                mem_delay = 1, cur_delay = 1, mcnt = 0;
  logic [DATA_W-1:0] mem_fixed = '0;

  int                cyc = 0;
  bit                strobe_prev = 0;
  logic [ADDR_W-1:0] addr_log [$];
  int                done_log [$];
  int                done_cyc [$];

  // Reference model: current owner and how many busy cycles it has had
  bit                m_busy, m_cool;
  int                m_owner, m_age, m_last;
  logic              e_oe, e_we, e_err;
  logic [1:0]        e_rdy;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [SIZE_W-1:0] e_size;
  logic [DATA_W-1:0] e_rdata [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cool = 0; m_owner = 0; m_age = 0; m_last = 1;
    e_oe = 0; e_we = 0; e_err = 0; e_rdy = '0;
    e_addr = '0; e_wdata = '0; e_size = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  task automatic model_step();
    bit ok0, ok1;
    int w;
    e_rdy = '0;
    if (m_cool) begin
      m_cool = 0;
    end else if (!m_busy) begin
      if ((r_oe[0] && r_we[0]) || (r_oe[1] && r_we[1])) e_err = 1;
      ok0 = (r_oe[0] != r_we[0]);
      ok1 = (r_oe[1] != r_we[1]);
      w = -1;
      if (ok0 && ok1) w = 1 - m_last;
      else if (ok0)   w = 0;
      else if (ok1)   w = 1;
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_age = 0;
        e_oe = r_oe[w]; e_we = r_we[w];
        e_addr = r_addr[w]; e_wdata = r_wdata[w]; e_size = r_size[w];
      end
    end else begin
      m_age++;
      if (mem_rdy || m_age == TIMEOUT) begin
        e_rdata[m_owner] = mem_rdy ? mem_rdata : '0;
        if (!mem_rdy) e_err = 1;
        e_rdy[m_owner] = 1'b1;
        e_oe = 0; e_we = 0;
        m_busy = 0; m_cool = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("cmp_strobes", 64'({mem_oe, mem_we}), 64'({e_oe, e_we}));
        check("cmp_addr", 64'(mem_addr), 64'(e_addr));
        check("cmp_wdata", 64'(mem_wdata), 64'(e_wdata));
        check("cmp_size", 64'(mem_size), 64'(e_size));
        check("cmp_rdy", 64'(req_rdy), 64'(e_rdy));
        check("cmp_rdata0", 64'(req_rdata[31:0]), 64'(e_rdata[0]));
        check("cmp_rdata1", 64'(req_rdata[63:32]), 64'(e_rdata[1]));
        check("cmp_err", 64'(err), 64'(e_err));
      end
    end
  end

  // Memory: answers delay cycles after the strobe appears, unless hung.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && (mem_oe || mem_we)) begin
        if (!mem_hang && mcnt == cur_delay - 1) begin
          mem_rdy = 1'b1;
          mem_rdata = mem_fixed_en ? mem_fixed : $urandom;
        end else begin
          mem_rdy = 1'b0;
          mem_rdata = $urandom;
        end
        mcnt++;
      end else begin
        mcnt = 0;
        cur_delay = rand_delay ? int'($urandom_range(1, 10)) : mem_delay;
        mem_rdy = spurious && ($urandom_range(0, 9) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  task automatic drive_req();
    req_oe    = {r_oe[1], r_oe[0]};
    req_we    = {r_we[1], r_we[0]};
    req_addr  = {r_addr[1], r_addr[0]};
    req_wdata = {r_wdata[1], r_wdata[0]};
    req_size  = {r_size[1], r_size[0]};
  endtask

  task automatic set_req(input int i, input logic oe, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [SIZE_W-1:0] s);
    r_oe[i] = oe; r_we[i] = we; r_addr[i] = a; r_wdata[i] = d; r_size[i] = s;
    drive_req();
  endtask

  task automatic random_req(input int i);
    int op;
    op = $urandom_range(0, 9);
    set_req(i, op < 5 || op == 0, op >= 5 || op == 0, ADDR_W'($urandom), $urandom, SIZE_W'($urandom));
    if (op == 0) bad_hold[i] = $urandom_range(1, 3);
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    if ((mem_oe || mem_we) && !strobe_prev) addr_log.push_back(mem_addr);
    strobe_prev = mem_oe || mem_we;
    for (int i = 0; i < 2; i++) begin
      if (req_rdy[i]) begin
        done_cnt[i]++;
        done_log.push_back(i);
        done_cyc.push_back(cyc);
        if (auto_rq[i]) set_req(i, 1'b1, 1'b0, ADDR_W'(12'h400 * (i + 1) + done_cnt[i]), $urandom, 6'd32);
        else set_req(i, 1'b0, 1'b0, r_addr[i], r_wdata[i], r_size[i]);
      end else if (bad_hold[i] > 0) begin
        bad_hold[i]--;
        if (bad_hold[i] == 0) set_req(i, 1'b0, 1'b0, r_addr[i], r_wdata[i], r_size[i]);
      end else if (rand_mode && !r_oe[i] && !r_we[i] && $urandom_range(0, 3) == 0) begin
        random_req(i);
      end
    end
    drive_req();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      r_oe[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_size[i] = '0;
      bad_hold[i] = 0; auto_rq[i] = 0;
    end
    drive_req();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    clear_reqs();
    strobe_prev = 0;
    #4 reset = 1'b1;
    step();
  endtask

  task automatic wait_rdy(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (req_rdy == 2'b00 && n < max);
    if (req_rdy == 2'b00) begin
      checks++; failures++;
      $display("FAIL wait_rdy: no req_rdy within %0d cycles", n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, busy, d0, d1;
    for (int i = 0; i < 2; i++) done_cnt[i] = 0;
    clear_reqs();
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_strobes", 64'({mem_oe, mem_we}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_rdy", 64'(req_rdy), 64'(0));
    check("rst_rdata", 64'(req_rdata), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b1;
    step();

    // Single read with 2-cycle memory latency
    mem_fixed_en = 1; mem_fixed = 32'hDEADBEEF; mem_delay = 2;
    step();
    set_req(0, 1'b1, 1'b0, 12'h010, '0, 6'd32);
    wait_rdy(20, n);
    check("t1_latency", 64'(n), 64'(3));
    check("t1_rdy", 64'(req_rdy), 64'(2'b01));
    check("t1_rdata", 64'(req_rdata[31:0]), 64'(32'hDEADBEEF));
    check("t1_oe_done", 64'(mem_oe), 64'(0));
    check("t1_addr", 64'(mem_addr), 64'(12'h010));
    step();
    check("t1_rdy_pulse", 64'(req_rdy), 64'(0));

    // Simultaneous first requests after reset
    mem_delay = 1; mem_fixed_en = 0;
    do_reset();
    addr_log.delete();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    set_req(0, 1'b1, 1'b0, 12'h100, '0, 6'd8);
    set_req(1, 1'b1, 1'b0, 12'h200, '0, 6'd8);
    n = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && n < 30) begin step(); n++; end
    check("t2_both_done", 64'(done_cnt[0] - d0 + done_cnt[1] - d1), 64'(2));
    if (addr_log.size() >= 2) begin
      check("t2_first_addr", 64'(addr_log[0]), 64'(12'h100));
      check("t2_second_addr", 64'(addr_log[1]), 64'(12'h200));
    end else check("t2_log_size", 64'(addr_log.size()), 64'(2));

    // Sustained contention, 8 accesses
    mem_delay = 2;
    step();
    done_log.delete(); done_cyc.delete();
    auto_rq[0] = 1; auto_rq[1] = 1;
    set_req(0, 1'b1, 1'b0, 12'h400, '0, 6'd32);
    set_req(1, 1'b1, 1'b0, 12'h800, '0, 6'd32);
    n = 0;
    while (done_log.size() < 8 && n < 60) begin step(); n++; end
    auto_rq[0] = 0; auto_rq[1] = 0;
    check("t3_count", 64'(done_log.size() >= 8), 64'(1));
    for (int k = 0; k < 8 && k < done_log.size(); k++) begin
      check("t3_order", 64'(done_log[k]), 64'(k % 2));
      if (k > 0) check("t3_spacing", 64'(done_cyc[k] - done_cyc[k-1]), 64'(4));
    end
    n = 0;
    while ((r_oe[0] || r_we[0] || r_oe[1] || r_we[1]) && n < 40) begin step(); n++; end
    check("t3_drained", 64'({r_oe[0], r_we[0], r_oe[1], r_we[1]}), 64'(0));

    // Write with size, fields held until the memory answers
    mem_delay = 3;
    step();
    set_req(1, 1'b0, 1'b1, 12'h020, 32'h12345678, 6'd32);
    n = 0; busy = 0;
    do begin
      step();
      n++;
      if (mem_we) begin
        busy++;
        check("t4_addr", 64'(mem_addr), 64'(12'h020));
        check("t4_wdata", 64'(mem_wdata), 64'(32'h12345678));
        check("t4_size", 64'(mem_size), 64'(32));
        check("t4_oe", 64'(mem_oe), 64'(0));
      end
    end while (req_rdy == 2'b00 && n < 20);
    check("t4_busy_cycles", 64'(busy), 64'(3));
    check("t4_rdy", 64'(req_rdy), 64'(2'b10));

    // Watchdog abort
    mem_hang = 1;
    step();
    set_req(0, 1'b1, 1'b0, 12'h030, '0, 6'd16);
    n = 0; busy = 0;
    do begin
      step();
      n++;
      if (mem_oe) busy++;
    end while (req_rdy == 2'b00 && n < 30);
    check("t5_busy_cycles", 64'(busy), 64'(TIMEOUT));
    check("t5_rdy", 64'(req_rdy), 64'(2'b01));
    check("t5_rdata", 64'(req_rdata[31:0]), 64'(0));
    check("t5_err", 64'(err), 64'(1));
    mem_hang = 0;
    repeat (3) step();
    check("t5_err_sticky", 64'(err), 64'(1));

    // Protocol error on requester 0 while requester 1 asks
    mem_delay = 1;
    do_reset();
    check("t6_err_cleared", 64'(err), 64'(0));
    d0 = done_cnt[0];
    set_req(0, 1'b1, 1'b1, 12'h040, '0, 6'd8);
    bad_hold[0] = 6;
    set_req(1, 1'b1, 1'b0, 12'h050, '0, 6'd8);
    step();
    check("t6_err", 64'(err), 64'(1));
    check("t6_grant", 64'({mem_oe, mem_we}), 64'(2'b10));
    check("t6_addr", 64'(mem_addr), 64'(12'h050));
    wait_rdy(20, n);
    check("t6_rdy", 64'(req_rdy), 64'(2'b10));
    repeat (8) step();
    check("t6_no_grant0", 64'(done_cnt[0] - d0), 64'(0));

    // Asynchronous reset in the middle of an access
    mem_hang = 1;
    step();
    set_req(0, 1'b1, 1'b0, 12'h060, 32'hCAFE0001, 6'd4);
    repeat (2) step();
    check("t7_busy", 64'(mem_oe), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("t7_strobes", 64'({mem_oe, mem_we}), 64'(0));
    check("t7_addr", 64'(mem_addr), 64'(0));
    check("t7_size", 64'(mem_size), 64'(0));
    check("t7_rdy", 64'(req_rdy), 64'(0));
    check("t7_rdata", 64'(req_rdata), 64'(0));
    check("t7_err", 64'(err), 64'(0));
    clear_reqs();
    strobe_prev = 0;
    #4 reset = 1'b1;
    mem_hang = 0;
    step();
    check("t7_no_pulse", 64'(req_rdy), 64'(0));

    // Randomized traffic with random latencies, timeouts and spurious mem_rdy
    d0 = done_cnt[0]; d1 = done_cnt[1];
    rand_mode = 1; rand_delay = 1; spurious = 1;
    repeat (1500) step();
    rand_mode = 0; spurious = 0;
    repeat (40) step();
    check("t8_activity", 64'(done_cnt[0] > d0 && done_cnt[1] > d1), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-to-one arbiter that shares a single external memory channel between the two master channels of a Bambu-generated `main` core. It sits between `main`'s packed `Mout_*` bus and the testbench/off-chip memory model. The block serializes accesses with round-robin fairness and holds each grant until the memory answers. A watchdog aborts any access the memory never completes.

## Interface
- `ADDR_W`, default 12: address bits per channel.
- `DATA_W`, default 32: data bits per channel.
- `SIZE_W`, default 6: access-size field bits per channel, in bits-per-access encoding.
- `TIMEOUT`, default 1024: maximum number of BUSY cycles before an abort.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_oe` in 2: per-requester read request; level, held until `req_rdy`.
- `req_we` in 2: per-requester write request; level, held until `req_rdy`.
- `req_addr` in 2*ADDR_W: requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_wdata` in 2*DATA_W: packed write data.
- `req_size` in 2*SIZE_W: packed access size.
- `req_rdata` out 2*DATA_W: packed read data; valid while `req_rdy[i]` is 1.
- `req_rdy` out 2: one-cycle completion pulse per requester.
- `mem_oe` out 1, `mem_we` out 1: memory read and write strobes.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_size` out SIZE_W: memory command fields.
- `mem_rdata` in DATA_W: memory read data.
- `mem_rdy` in 1: memory completion, asserted for one cycle.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE.** A requester is pending when `req_oe[i] | req_we[i]`.
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the requester that is not `last_gnt`.
  - On a grant: register `gnt`, set `last_gnt <= gnt`, latch that requester's oe/we/addr/wdata/size into the `mem_*` registers, clear the watchdog, go to BUSY.
- **BUSY.**
  - Hold all `mem_*` outputs constant and increment the watchdog.
  - On `mem_rdy=1`:
    - Copy `mem_rdata` into slot `gnt` of `req_rdata`. The other slot keeps its old value.
    - Pulse `req_rdy[gnt]`.
    - Drop `mem_oe`/`mem_we`.
    - Go to DONE.
  - When the watchdog reaches TIMEOUT-1 with no `mem_rdy`:
    - Set `err`, write 0 into `req_rdata` slot `gnt`, pulse `req_rdy[gnt]`.
    - Drop the strobes and go to DONE.
- **DONE.** Go unconditionally to IDLE. Requests are ignored in this state because the granted master still shows its stale strobe for this one cycle.
- **Protocol error.** If `req_oe[i]` and `req_we[i]` are both 1 while IDLE, set `err` and do not grant that requester. The other requester may still be granted.
- **Write accesses.** Handled identically to reads. The `req_rdata` slot is still written with whatever `mem_rdata` carries.
- **Reset values.**
  - State IDLE, `last_gnt=1` so requester 0 wins the first tie.
  - `mem_oe=mem_we=0`; `mem_addr`, `mem_wdata`, `mem_size` all 0.
  - `req_rdy=0`, `req_rdata=0`, `err=0`, watchdog 0.
- **Reset mid-operation.** An asynchronous reset during BUSY drops the strobes immediately. No `req_rdy` pulse is generated.

## Timing
- All outputs are registered; there are no combinational paths from request inputs to `mem_*` outputs.
- Grant latency: a request sampled at edge n drives `mem_*` after edge n.
- Completion latency: `mem_rdy` sampled at edge k produces `req_rdy` high from edge k to edge k+1.
- Minimum occupancy per access: 3 cycles (IDLE, BUSY, DONE). With a memory read delay of 2, a read occupies 4 cycles.
- Back-to-back requests from both masters alternate strictly; neither can starve the other.
- `mem_rdy` arriving in IDLE or DONE is ignored.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum {IDLE, BUSY, DONE};
  - default width constants ADDR_W, DATA_W, SIZE_W;
  - a helper function that slices a packed channel.
- One natural sub-module: `rr_pick2`, a combinational two-way round-robin selector with inputs `pending[1:0]` and `last_gnt`, and outputs `gnt` and `valid`. Everything else stays in a single module.
- The watchdog counter is $clog2(TIMEOUT) bits wide and saturates at its terminal value; it never wraps.

## Test plan
- **Single read.**
  - Stimulus: `req_oe=2'b01`, addr 0x010; memory returns 0xDEADBEEF with `mem_rdy` 2 cycles after `mem_oe`.
  - Response: `req_rdy=2'b01` for exactly one cycle; `req_rdata[31:0]=0xDEADBEEF`; `mem_oe` low in DONE.
- **Simultaneous first requests.**
  - Stimulus: both requesters raise `req_oe` on the same cycle after reset.
  - Response: requester 0 is served first, then requester 1. `mem_addr` sequence equals addr0, then addr1.
- **Sustained contention.**
  - Stimulus: both requesters re-request immediately after each `req_rdy`, for 8 accesses.
  - Response: grants alternate 0,1,0,1,…; each access is spaced 4 cycles apart.
- **Write with size.**
  - Stimulus: `req_we[1]=1`, addr 0x020, wdata 0x12345678, size 32.
  - Response: `mem_we=1`, `mem_addr=0x020`, `mem_wdata=0x12345678`, `mem_size=32`, all held stable until `mem_rdy`. Then `req_rdy=2'b10`.
- **Timeout.**
  - Stimulus: TIMEOUT=8; the memory never asserts `mem_rdy`.
  - Response: after 8 BUSY cycles, `req_rdy` pulses, `req_rdata` slot is 0, and `err` goes to 1 and stays 1.
- **Protocol error and mid-access reset.**
  - Stimulus: `req_oe[0]=req_we[0]=1` while `req_oe[1]=1`.
  - Response: `err=1` and only requester 1 is granted.
  - Stimulus: assert `reset` low during BUSY.
  - Response: all outputs return to their reset values asynchronously.
